branch_update_queue: RTL and testbench
======================================

# branch_update_queue

In-order queue between fetch/decode and execute that holds the prediction made for every in-flight control-flow instruction. When execute resolves the oldest branch, the block compares the outcome against the stored prediction and raises a registered mispredict/redirect. It also issues a one-cycle training write into the branch predictor's update port. It flushes wrong-path entries on a mispredict or on an external flush.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, ≥2
- ADDR_W, 32, PC/target width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- push_valid  in  1  decode offers a control-flow instruction
- push_ready  out  1  queue accepts the push this cycle
- push_pc  in  ADDR_W  PC of the instruction
- push_taken  in  1  predicted direction
- push_target  in  ADDR_W  predicted target; ignored if not taken
- resolve_valid  in  1  execute resolves the oldest branch
- resolve_pc  in  ADDR_W  PC of the resolved instruction
- resolve_taken  in  1  actual direction
- resolve_target  in  ADDR_W  actual taken target
- flush  in  1  exception/trap flush; discards all entries
- mispredict  out  1  registered one-cycle redirect pulse
- redirect_pc  out  ADDR_W  correct next PC, valid with mispredict
- update_valid  out  1  registered one-cycle predictor training pulse
- update_pc, update_target  out  ADDR_W  training PC/target
- update_taken  out  1  training direction
- order_err  out  1  sticky; resolve on empty queue or PC mismatch
- count  out  $clog2(DEPTH+1)  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits with natural wrap, plus occupancy counter.
- push_ready = !full && !mispredict. This is combinational from registered state only. A push accepted while mispredict is high is prohibited because it is wrong-path.
- Push fires on push_valid && push_ready and writes the entry at tail.
- Resolve on a non-empty queue with resolve_pc == head.pc:
  - pop head;
  - wrong = (resolve_taken != head.taken) || (resolve_taken && resolve_target != head.target);
  - training: update_valid=1, update_pc=head.pc, update_taken=resolve_taken, update_target=resolve_target;
  - if wrong: mispredict=1, redirect_pc = resolve_taken ? resolve_target : head.pc+4 (mod 2^ADDR_W), and every remaining entry plus any simultaneous push is discarded (count→0).
- Resolve on an empty queue, or with a PC mismatch:
  - set order_err, which clears only on RST;
  - no pop, update or mispredict.
- Simultaneous push + correct resolve (no mispredict): both take effect and count is unchanged. When full, push_ready=0 even if a resolve occurs the same cycle.
- flush has the highest priority:
  - queue empties;
  - a simultaneous push or resolve is discarded;
  - no update or mispredict is generated that cycle;
  - a mispredict registered the previous cycle still pulses.

## Timing
- Reset values: count=0, empty=1, full=0, push_ready=1, mispredict=0, update_valid=0, order_err=0, redirect_pc=0, update_* = 0, pointers=0.
- Resolve→mispredict/update latency: exactly 1 cycle. Both are pulses of exactly one cycle.
- Push→entry visible at head: 1 cycle. A push to an empty queue can be resolved the following cycle.
- Back-to-back resolves every cycle are supported. Each produces its own update pulse.
- RST asserted mid-operation clears all state immediately. Outputs return to their reset values without waiting for CLK.

## Structure
- Shared package branch_pkg holds:
  - typedef bq_entry_t, a packed struct {pc, taken, target};
  - constant INSTR_BYTES=4 used for the fall-through PC.
- One natural sub-module, bq_fifo: parameterized circular buffer of bq_entry_t with push/pop/clear and count/full/empty. The compare, redirect and training logic sits in branch_update_queue.

## Test plan
- Reset: RST high mid-run with count=3 → count=0, empty=1, push_ready=1, all pulses 0 asynchronously.
- Correct prediction:
  - stimulus: push {pc=0x100, taken=1, target=0x200}, then resolve {0x100, 1, 0x200};
  - response: next cycle update_valid=1, update_pc=0x100, update_taken=1, update_target=0x200; mispredict=0; count=0.
- Direction mispredict:
  - stimulus: push {0x100, 1, 0x200}, push {0x104, 0, 0}, then resolve {0x100, 0, x};
  - response: mispredict=1, redirect_pc=0x104, count=0; push_ready=0 during the pulse.
- Target mispredict: push {0x300, 1, 0x400}, resolve {0x300, 1, 0x480} → mispredict=1, redirect_pc=0x480, update_target=0x480.
- Full/wrap:
  - stimulus: push 4 entries, then push_valid held;
  - response: full=1, push_ready=0; one resolve plus next push wraps tail to 0; six in-order resolves pop in FIFO order.
- Errors and flush:
  - resolve on empty → order_err=1 (sticky), no update;
  - flush concurrent with resolve and push → count=0, no update/mispredict.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch update queue.
package branch_pkg;

  localparam int unsigned BQ_ADDR_W   = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [BQ_ADDR_W-1:0] pc;
    logic                 taken;
    logic [BQ_ADDR_W-1:0] target;
  } bq_entry_t;

endpackage

// File: rtl/branch_update_queue_if.sv
// Push / resolve / redirect / training bundle between decode, execute and the queue.
interface branch_update_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              push_valid;
  logic              push_ready;
  logic [ADDR_W-1:0] push_pc;
  logic              push_taken;
  logic [ADDR_W-1:0] push_target;
  logic              resolve_valid;
  logic [ADDR_W-1:0] resolve_pc;
  logic              resolve_taken;
  logic [ADDR_W-1:0] resolve_target;
  logic              flush;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic              update_valid;
  logic [ADDR_W-1:0] update_pc;
  logic [ADDR_W-1:0] update_target;
  logic              update_taken;
  logic              order_err;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output push_valid, push_pc, push_taken, push_target,
           resolve_valid, resolve_pc, resolve_taken, resolve_target, flush,
    input  push_ready, mispredict, redirect_pc, update_valid, update_pc,
           update_target, update_taken, order_err, count, empty, full
  );

  modport slave (
    input  push_valid, push_pc, push_taken, push_target,
           resolve_valid, resolve_pc, resolve_taken, resolve_target, flush,
    output push_ready, mispredict, redirect_pc, update_valid, update_pc,
           update_target, update_taken, order_err, count, empty, full
  );
endinterface

// File: rtl/bq_fifo.sv
// Circular buffer of branch predictions with push/pop/clear and occupancy.
module bq_fifo
  import branch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  bq_entry_t     i_wdata,
  output bq_entry_t     o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  bq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_tail] <= i_wdata;
  end

  always_comb begin
    o_rdata = r_mem[r_head];
    o_count = r_count;
    o_full  = (r_count == CW'(DEPTH));
    o_empty = (r_count == '0);
  end

endmodule

// File: rtl/branch_update_queue.sv
// In-order prediction queue: checks execute's resolution against the stored
// prediction, emits registered redirect and predictor-training pulses.
module branch_update_queue
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = BQ_ADDR_W
) (
  input logic                  CLK,
  input logic                  RST,
  branch_update_queue_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  bq_entry_t         w_head;
  bq_entry_t         w_push_entry;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ready;
  logic              w_push_fire;
  logic              w_pc_match;
  logic              w_res_ok;
  logic              w_res_err;
  logic              w_wrong;
  logic              w_clear;
  logic [ADDR_W-1:0] w_head_pc;
  logic [ADDR_W-1:0] w_head_target;
  logic [ADDR_W-1:0] w_redirect;

  logic              r_mispredict;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_update_valid;
  logic [ADDR_W-1:0] r_update_pc;
  logic              r_update_taken;
  logic [ADDR_W-1:0] r_update_target;
  logic              r_order_err;

  always_comb begin
    w_push_entry.pc     = BQ_ADDR_W'(bus.push_pc);
    w_push_entry.taken  = bus.push_taken;
    w_push_entry.target = BQ_ADDR_W'(bus.push_target);
    w_head_pc           = ADDR_W'(w_head.pc);
    w_head_target       = ADDR_W'(w_head.target);

    // A pending redirect blocks pushes: anything arriving then is wrong-path.
    w_push_ready = !w_full && !r_mispredict;
    w_push_fire  = bus.push_valid && w_push_ready && !bus.flush;

    w_pc_match = !w_empty && (bus.resolve_pc == w_head_pc);
    w_res_ok   = bus.resolve_valid && !bus.flush && w_pc_match;
    w_res_err  = bus.resolve_valid && !bus.flush && !w_pc_match;
    w_wrong    = w_res_ok &&
                 ((bus.resolve_taken != w_head.taken) ||
                  (bus.resolve_taken && (bus.resolve_target != w_head_target)));
    w_redirect = bus.resolve_taken ? bus.resolve_target
                                   : w_head_pc + ADDR_W'(INSTR_BYTES);
    w_clear    = bus.flush || w_wrong;
  end

  bq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push_fire),
    .i_pop   (w_res_ok),
    .i_clear (w_clear),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mispredict    <= 1'b0;
      r_redirect_pc   <= '0;
      r_update_valid  <= 1'b0;
      r_update_pc     <= '0;
      r_update_taken  <= 1'b0;
      r_update_target <= '0;
      r_order_err     <= 1'b0;
    end else begin
      r_mispredict   <= w_wrong;
      r_update_valid <= w_res_ok;
      if (w_wrong) r_redirect_pc <= w_redirect;
      if (w_res_ok) begin
        r_update_pc     <= w_head_pc;
        r_update_taken  <= bus.resolve_taken;
        r_update_target <= bus.resolve_target;
      end
      if (w_res_err) r_order_err <= 1'b1;
    end
  end

  always_comb begin
    bus.push_ready    = w_push_ready;
    bus.mispredict    = r_mispredict;
    bus.redirect_pc   = r_redirect_pc;
    bus.update_valid  = r_update_valid;
    bus.update_pc     = r_update_pc;
    bus.update_taken  = r_update_taken;
    bus.update_target = r_update_target;
    bus.order_err     = r_order_err;
    bus.count         = w_count;
    bus.empty         = w_empty;
    bus.full          = w_full;
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed vector bench for branch_update_queue (DEPTH=4, ADDR_W=32).
module tb_branch_update_queue;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int          NVEC   = 33;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  branch_update_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  branch_update_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        pv;  logic [31:0] ppc; logic pt; logic [31:0] ptg;
    logic        rv;  logic [31:0] rpc; logic rt; logic [31:0] rtg;
    logic        fl;
    int          ecnt;
    logic        erdy; logic emp; logic [31:0] erdpc;
    logic        euv;  logic [31:0] eupc; logic eut; logic [31:0] eutg;
    logic        eoe;
  } vec_t;

  vec_t vecs [NVEC];
  int applied     = 0;
  int miscompares = 0;

  function automatic vec_t mk(
    logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptg,
    logic rv, logic [31:0] rpc, logic rt, logic [31:0] rtg, logic fl,
    int ecnt, logic erdy, logic emp, logic [31:0] erdpc,
    logic euv, logic [31:0] eupc, logic eut, logic [31:0] eutg, logic eoe);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.pt = pt; v.ptg = ptg;
    v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtg = rtg; v.fl = fl;
    v.ecnt = ecnt; v.erdy = erdy; v.emp = emp; v.erdpc = erdpc;
    v.euv = euv; v.eupc = eupc; v.eut = eut; v.eutg = eutg; v.eoe = eoe;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.push_valid     = v.pv;
    bus.push_pc        = v.ppc;
    bus.push_taken     = v.pt;
    bus.push_target    = v.ptg;
    bus.resolve_valid  = v.rv;
    bus.resolve_pc     = v.rpc;
    bus.resolve_taken  = v.rt;
    bus.resolve_target = v.rtg;
    bus.flush          = v.fl;
  endtask

  task automatic check_vec(input string name, input vec_t v);
    logic ok;
    ok = (int'(bus.count) == v.ecnt) && (bus.empty == (v.ecnt == 0)) &&
         (bus.full == (v.ecnt == DEPTH)) && (bus.push_ready == v.erdy) &&
         (bus.mispredict == v.emp) && (bus.update_valid == v.euv) &&
         (bus.order_err == v.eoe);
    if (v.emp) ok = ok && (bus.redirect_pc == v.erdpc);
    if (v.euv) ok = ok && (bus.update_pc == v.eupc) &&
                   (bus.update_taken == v.eut) && (bus.update_target == v.eutg);
    applied++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d rdy=%0b mp=%0b rd=%h uv=%0b upc=%h ut=%0b utg=%h oe=%0b e=%0b f=%0b | want cnt=%0d rdy=%0b mp=%0b rd=%h uv=%0b upc=%h ut=%0b utg=%h oe=%0b",
               name, bus.count, bus.push_ready, bus.mispredict, bus.redirect_pc,
               bus.update_valid, bus.update_pc, bus.update_taken, bus.update_target,
               bus.order_err, bus.empty, bus.full,
               v.ecnt, v.erdy, v.emp, v.erdpc, v.euv, v.eupc, v.eut, v.eutg, v.eoe);
    end
  endtask

  task automatic check_reset_state(input string name);
    vec_t r;
    r = mk(0,0,0,0, 0,0,0,0, 0, 0,1,0,0, 0,0,0,0, 0);
    applied++;
    if (bus.count != '0 || !bus.empty || bus.full || !bus.push_ready ||
        bus.mispredict || bus.update_valid || bus.order_err ||
        bus.redirect_pc != '0 || bus.update_pc != '0 || bus.update_taken ||
        bus.update_target != '0) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d e=%0b f=%0b rdy=%0b mp=%0b uv=%0b oe=%0b rd=%h upc=%h ut=%0b utg=%h, want all reset values (cnt=%0d rdy=%0b)",
               name, bus.count, bus.empty, bus.full, bus.push_ready, bus.mispredict,
               bus.update_valid, bus.order_err, bus.redirect_pc, bus.update_pc,
               bus.update_taken, bus.update_target, r.ecnt, r.erdy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0, 0,0,0,0, 0, 0,1,0,0, 0,0,0,0, 0);

    //          push pv,pc,t,tg         resolve rv,pc,t,tg      fl  cnt rdy mp redirect uv upc ut utg oe
    vecs[0]  = mk(1,32'h100,1,32'h200, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[1]  = mk(0,0,0,0,             1,32'h100,1,32'h200,     0, 0,1,0,0, 1,32'h100,1,32'h200, 0);
    vecs[2]  = mk(0,0,0,0,             0,0,0,0,                 0, 0,1,0,0, 0,0,0,0, 0);
    vecs[3]  = mk(1,32'h100,1,32'h200, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[4]  = mk(1,32'h104,0,0,       0,0,0,0,                 0, 2,1,0,0, 0,0,0,0, 0);
    vecs[5]  = mk(1,32'h108,0,0,       1,32'h100,0,0,           0, 0,0,1,32'h104, 1,32'h100,0,0, 0);
    vecs[6]  = mk(1,32'h500,0,0,       0,0,0,0,                 0, 0,1,0,0, 0,0,0,0, 0);
    vecs[7]  = mk(1,32'h300,1,32'h400, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[8]  = mk(0,0,0,0,             1,32'h300,1,32'h480,     0, 0,0,1,32'h480, 1,32'h300,1,32'h480, 0);
    vecs[9]  = mk(0,0,0,0,             0,0,0,0,                 0, 0,1,0,0, 0,0,0,0, 0);
    vecs[10] = mk(1,32'h600,0,0,       0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[11] = mk(0,0,0,0,             1,32'h600,1,32'h700,     0, 0,0,1,32'h700, 1,32'h600,1,32'h700, 0);
    vecs[12] = mk(0,0,0,0,             0,0,0,0,                 0, 0,1,0,0, 0,0,0,0, 0);
    vecs[13] = mk(1,32'h800,0,32'h123, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[14] = mk(0,0,0,0,             1,32'h800,0,32'h999,     0, 0,1,0,0, 1,32'h800,0,32'h999, 0);
    vecs[15] = mk(1,32'hA00,0,0,       0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[16] = mk(1,32'hA04,0,0,       0,0,0,0,                 0, 2,1,0,0, 0,0,0,0, 0);
    vecs[17] = mk(1,32'hA08,1,32'hC00, 0,0,0,0,                 0, 3,1,0,0, 0,0,0,0, 0);
    vecs[18] = mk(1,32'hA0C,0,0,       0,0,0,0,                 0, 4,0,0,0, 0,0,0,0, 0);
    vecs[19] = mk(1,32'hA10,0,0,       1,32'hA00,0,0,           0, 3,1,0,0, 1,32'hA00,0,0, 0);
    vecs[20] = mk(1,32'hA10,0,0,       0,0,0,0,                 0, 4,0,0,0, 0,0,0,0, 0);
    vecs[21] = mk(1,32'hA14,0,0,       1,32'hA04,0,0,           0, 3,1,0,0, 1,32'hA04,0,0, 0);
    vecs[22] = mk(1,32'hA14,0,0,       1,32'hA08,1,32'hC00,     0, 3,1,0,0, 1,32'hA08,1,32'hC00, 0);
    vecs[23] = mk(0,0,0,0,             1,32'hA0C,0,0,           0, 2,1,0,0, 1,32'hA0C,0,0, 0);
    vecs[24] = mk(0,0,0,0,             1,32'hA10,0,0,           0, 1,1,0,0, 1,32'hA10,0,0, 0);
    vecs[25] = mk(0,0,0,0,             1,32'hA14,0,0,           0, 0,1,0,0, 1,32'hA14,0,0, 0);
    vecs[26] = mk(1,32'hC00,1,32'hC40, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 0);
    vecs[27] = mk(0,0,0,0,             1,32'hC04,1,32'hC40,     0, 1,1,0,0, 0,0,0,0, 1);
    vecs[28] = mk(0,0,0,0,             1,32'hC00,1,32'hC40,     0, 0,1,0,0, 1,32'hC00,1,32'hC40, 1);
    vecs[29] = mk(0,0,0,0,             1,32'h900,0,0,           0, 0,1,0,0, 0,0,0,0, 1);
    vecs[30] = mk(1,32'hB00,1,32'hB80, 0,0,0,0,                 0, 1,1,0,0, 0,0,0,0, 1);
    vecs[31] = mk(1,32'hB04,0,0,       1,32'hB00,1,32'hBFF,     1, 0,1,0,0, 0,0,0,0, 1);
    vecs[32] = mk(0,0,0,0,             0,0,0,0,                 0, 0,1,0,0, 0,0,0,0, 1);

    drive(idle);
    RST = 1'b1;
    #12;
    check_reset_state("reset_initial");
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      @(posedge CLK);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Fill to three entries, then hit RST between clock edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(mk(1, 32'hD00 + 32'(4 * i), 0, 0, 0,0,0,0, 0, 0,1,0,0, 0,0,0,0, 0));
      @(posedge CLK);
    end
    @(negedge CLK);
    drive(idle);
    #1;
    check_vec("count3_before_reset",
              mk(0,0,0,0, 0,0,0,0, 0, 3,1,0,0, 0,0,0,0, 1));
    #1;
    RST = 1'b1;
    #1;
    check_reset_state("reset_async");
    @(negedge CLK);
    RST = 1'b0;

    // Push into the freshly reset queue and resolve it on the next cycle.
    @(negedge CLK);
    drive(mk(1,32'hE00,1,32'hE80, 0,0,0,0, 0, 0,1,0,0, 0,0,0,0, 0));
    @(posedge CLK);
    @(negedge CLK);
    drive(mk(0,0,0,0, 1,32'hE00,0,0, 0, 0,1,0,0, 0,0,0,0, 0));
    @(posedge CLK);
    #1;
    check_vec("post_reset_mispredict",
              mk(0,0,0,0, 0,0,0,0, 0, 0,0,1,32'hE04, 1,32'hE00,0,0, 0));
    @(negedge CLK);
    drive(idle);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
